// File: rtl/except_pkg.sv
// Shared definitions for the M-stage exception controller: ExcCodes, CP0 register
// numbers, FSM state encoding and the latched exception record.
package except_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic [4:0]  exccode;
        logic        is_eret;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badvaddr;
        logic        bva_we;
        logic [31:0] newpc;
    } exc_rec_t;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// Level synchroniser for the external interrupt lines: a STAGES-deep flop chain
// per line, cleared by the synchronous reset.
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// Registered M-stage exception controller: resolves priority, holds off while a data
// transaction is outstanding, then pulses flush/commit. Optional timer: TIMER_INT_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no event held; detect and latch a new exception or ERET
// ST_WAIT_MEM | event latched, data transaction outstanding, stall_req=1
// ST_FLUSH    | flush (and exc_commit unless ERET) high for this one cycle
module except_ctrl
    import except_pkg::*;
#(
    parameter int          N_EXT_INT   = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hbfc00380
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_EXT_INT-1:0] ext_int,
    input  logic                 valid_m,
    input  logic [31:0]          pc_m,
    input  logic                 in_ds_m,
    input  logic [31:0]          daddr_m,
    input  logic                 adel_if,
    input  logic                 ri,
    input  logic                 ov,
    input  logic                 sys,
    input  logic                 bp,
    input  logic                 eret,
    input  logic                 adel_d,
    input  logic                 ades,
    input  logic [31:0]          status,
    input  logic [1:0]           cause_sw,
    input  logic [31:0]          epc,
    input  logic                 cp0_we,
    input  logic [4:0]           cp0_waddr,
    input  logic [31:0]          cp0_wdata,
    input  logic                 mem_busy,
    output logic                 stall_req,
    output logic                 flush,
    output logic [31:0]          newpc,
    output logic                 exc_commit,
    output logic                 is_eret,
    output logic [4:0]           exccode,
    output logic [31:0]          epc_o,
    output logic                 bd_o,
    output logic [31:0]          badvaddr_o,
    output logic                 bva_we,
    output logic [5:0]           hw_ip
);

    logic [N_EXT_INT-1:0] sync_w;
    logic [5:0]           ext_ip_w;

    int_sync #(
        .WIDTH  (N_EXT_INT),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_int),
        .sync_o  (sync_w)
    );

    // Lines beyond N_EXT_INT read as zero in Cause.IP.
    always_comb begin
        ext_ip_w = '0;
        ext_ip_w[N_EXT_INT-1:0] = sync_w;
    end

`ifdef TIMER_INT_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;
    logic        timer_pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q         <= '0;
            compare_q       <= '0;
            tick_q          <= 1'b0;
            timer_pending_q <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (cp0_we && cp0_waddr == CP0_COUNT) begin
                count_q <= cp0_wdata;
            end else if (tick_q) begin
                count_q <= count_q + 32'd1;
            end
            // A Compare write acknowledges the timer; it wins over a same-cycle match.
            if (cp0_we && cp0_waddr == CP0_COMPARE) begin
                compare_q       <= cp0_wdata;
                timer_pending_q <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_pending_q <= 1'b1;
            end
        end
    end

    assign hw_ip = ext_ip_w | {timer_pending_q, 5'b0};

    logic unused_w;
    assign unused_w = ^{status[31:16], status[7:2]};
`else
    assign hw_ip = ext_ip_w;

    logic unused_w;
    assign unused_w = ^{status[31:16], status[7:2], cp0_we, cp0_waddr, cp0_wdata};
`endif

    logic     int_pend_w;
    logic     event_w;
    exc_rec_t rec_d;

    always_comb begin
        int_pend_w = valid_m && status[0] && !status[1]
                     && (|({hw_ip, cause_sw} & status[15:8]));
        event_w          = 1'b1;
        rec_d            = '0;
        rec_d.epc        = in_ds_m ? (pc_m - 32'd4) : pc_m;
        rec_d.bd         = in_ds_m;
        rec_d.newpc      = EXC_VECTOR;
        if (!valid_m) begin
            event_w = 1'b0;
        end else if (int_pend_w) begin
            rec_d.exccode = EXC_INT;
        end else if (adel_if) begin
            rec_d.exccode  = EXC_ADEL;
            rec_d.badvaddr = pc_m;
            rec_d.bva_we   = 1'b1;
        end else if (ri) begin
            rec_d.exccode = EXC_RI;
        end else if (ov) begin
            rec_d.exccode = EXC_OV;
        end else if (sys) begin
            rec_d.exccode = EXC_SYS;
        end else if (bp) begin
            rec_d.exccode = EXC_BP;
        end else if (eret) begin
            rec_d.is_eret = 1'b1;
            rec_d.newpc   = epc;
        end else if (adel_d) begin
            rec_d.exccode  = EXC_ADEL;
            rec_d.badvaddr = daddr_m;
            rec_d.bva_we   = 1'b1;
        end else if (ades) begin
            rec_d.exccode  = EXC_ADES;
            rec_d.badvaddr = daddr_m;
            rec_d.bva_we   = 1'b1;
        end else begin
            event_w = 1'b0;
        end
    end

    exc_state_e state_q;
    exc_rec_t   rec_q;
    logic       flush_q;
    logic       commit_q;
    logic       stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rec_q    <= '0;
            flush_q  <= 1'b0;
            commit_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            flush_q  <= 1'b0;
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (event_w) begin
                        rec_q <= rec_d;
                        if (mem_busy) begin
                            state_q <= ST_WAIT_MEM;
                            stall_q <= 1'b1;
                        end else begin
                            state_q  <= ST_FLUSH;
                            flush_q  <= 1'b1;
                            commit_q <= !rec_d.is_eret;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (!mem_busy) begin
                        state_q  <= ST_FLUSH;
                        stall_q  <= 1'b0;
                        flush_q  <= 1'b1;
                        commit_q <= !rec_q.is_eret;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_req  = stall_q;
    assign flush      = flush_q;
    assign exc_commit = commit_q;
    assign newpc      = rec_q.newpc;
    assign is_eret    = rec_q.is_eret;
    assign exccode    = rec_q.exccode;
    assign epc_o      = rec_q.epc;
    assign bd_o       = rec_q.bd;
    assign badvaddr_o = rec_q.badvaddr;
    assign bva_we     = rec_q.bva_we;

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed vector table, hand-written multi-cycle
// sequences, and a randomized trace checked against a trace-level reference model.
module tb_except_ctrl;
    import except_pkg::*;

    localparam int          NEXT = 6;
    localparam int          S    = 2;
    localparam logic [31:0] VEC  = 32'hbfc00380;
    localparam int          NC   = 600;
    localparam int          NV   = 10;

    localparam logic [7:0] F_ADEL_IF = 8'h80;
    localparam logic [7:0] F_RI      = 8'h40;
    localparam logic [7:0] F_OV      = 8'h20;
    localparam logic [7:0] F_SYS     = 8'h10;
    localparam logic [7:0] F_BP      = 8'h08;
    localparam logic [7:0] F_ERET    = 8'h04;
    localparam logic [7:0] F_ADEL_D  = 8'h02;
    localparam logic [7:0] F_ADES    = 8'h01;

    typedef struct packed {
        logic [5:0]  ext;
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] daddr;
        logic [7:0]  flags;
        logic [31:0] status;
        logic [1:0]  csw;
        logic [31:0] epc;
        logic        busy;
    } stim_t;

    typedef struct packed {
        logic        ev;
        logic [4:0]  code;
        logic        eret;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] bva;
        logic        bva_we;
        logic [31:0] newpc;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [NEXT-1:0] ext_int;
    logic            valid_m, in_ds_m;
    logic [31:0]     pc_m, daddr_m, status, epc, cp0_wdata;
    logic            adel_if, ri, ov, sys, bp, eret, adel_d, ades;
    logic [1:0]      cause_sw;
    logic            cp0_we;
    logic [4:0]      cp0_waddr;
    logic            mem_busy;
    logic            stall_req, flush, exc_commit, is_eret, bd_o, bva_we;
    logic [31:0]     newpc, epc_o, badvaddr_o;
    logic [4:0]      exccode;
    logic [5:0]      hw_ip;

    except_ctrl #(
        .N_EXT_INT   (NEXT),
        .SYNC_STAGES (S),
        .EXC_VECTOR  (VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_int    (ext_int),
        .valid_m    (valid_m),
        .pc_m       (pc_m),
        .in_ds_m    (in_ds_m),
        .daddr_m    (daddr_m),
        .adel_if    (adel_if),
        .ri         (ri),
        .ov         (ov),
        .sys        (sys),
        .bp         (bp),
        .eret       (eret),
        .adel_d     (adel_d),
        .ades       (ades),
        .status     (status),
        .cause_sw   (cause_sw),
        .epc        (epc),
        .cp0_we     (cp0_we),
        .cp0_waddr  (cp0_waddr),
        .cp0_wdata  (cp0_wdata),
        .mem_busy   (mem_busy),
        .stall_req  (stall_req),
        .flush      (flush),
        .newpc      (newpc),
        .exc_commit (exc_commit),
        .is_eret    (is_eret),
        .exccode    (exccode),
        .epc_o      (epc_o),
        .bd_o       (bd_o),
        .badvaddr_o (badvaddr_o),
        .bva_we     (bva_we),
        .hw_ip      (hw_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input stim_t s);
        ext_int  = s.ext;
        valid_m  = s.valid;
        pc_m     = s.pc;
        in_ds_m  = s.ds;
        daddr_m  = s.daddr;
        {adel_if, ri, ov, sys, bp, eret, adel_d, ades} = s.flags;
        status   = s.status;
        cause_sw = s.csw;
        epc      = s.epc;
        mem_busy = s.busy;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        drive('0);
        cp0_we    = 1'b0;
        cp0_waddr = '0;
        cp0_wdata = '0;
        tick();
        rst = 1'b0;
    endtask

    // Compare every record output against an expected flush-cycle record.
    task automatic check_rec(input string tag, input exp_t e);
        check({tag, " flush"},  flush, 1);
        check({tag, " commit"}, exc_commit, !e.eret);
        check({tag, " is_eret"}, is_eret, e.eret);
        check({tag, " newpc"},  newpc, e.newpc);
        check({tag, " epc_o"},  epc_o, e.epc);
        check({tag, " bd_o"},   bd_o, e.bd);
        check({tag, " bva_we"}, bva_we, e.bva_we);
        check({tag, " stall"},  stall_req, 0);
        if (!e.eret) check({tag, " exccode"}, exccode, e.code);
        if (e.bva_we) check({tag, " badvaddr"}, badvaddr_o, e.bva);
    endtask

    function automatic stim_t mk_s(input logic [7:0] f, input logic [31:0] pc, input logic ds,
                                   input logic [31:0] da, input logic [31:0] ep, input logic v);
        stim_t s;
        s = '0;
        s.valid = v; s.flags = f; s.pc = pc; s.ds = ds; s.daddr = da; s.epc = ep;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic ev, input logic [4:0] code, input logic er,
                                  input logic [31:0] ep, input logic bd, input logic [31:0] bva,
                                  input logic bw, input logic [31:0] np);
        exp_t e;
        e = '0;
        e.ev = ev; e.code = code; e.eret = er; e.epc = ep; e.bd = bd;
        e.bva = bva; e.bva_we = bw; e.newpc = np;
        return e;
    endfunction

    // What a single detection cycle should latch, given that cycle's inputs and Cause.IP.
    function automatic exp_t model(input stim_t s, input logic [5:0] hwip);
        logic [4:0] codes [8];
        logic       int_on;
        exp_t       e;
        codes = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h00, 5'h04, 5'h05};
        e = '0;
        e.epc = s.ds ? s.pc - 32'd4 : s.pc;
        e.bd  = s.ds;
        if (!s.valid) return e;
        int_on = (({hwip, s.csw} & s.status[15:8]) != 8'h00) && !s.status[1] && s.status[0];
        if (int_on) begin
            e.ev = 1'b1; e.code = 5'h00; e.newpc = VEC;
            return e;
        end
        for (int k = 0; k < 8; k++) begin
            if (s.flags[7-k]) begin
                e.ev   = 1'b1;
                e.code = codes[k];
                e.eret = (k == 5);
                if (k == 0) begin e.bva = s.pc;    e.bva_we = 1'b1; end
                if (k >= 6) begin e.bva = s.daddr; e.bva_we = 1'b1; end
                e.newpc = e.eret ? s.epc : VEC;
                return e;
            end
        end
        return e;
    endfunction

    vec_t        vecs [NV];
    stim_t       st   [NC];
    exp_t        vis  [NC];
    logic [5:0]  hw   [NC];
    logic        fl   [NC+2];
    logic        stl  [NC+2];
    logic        cm   [NC+2];

    initial begin
        stim_t s;
        exp_t  e, cur;
        int    n, nst, next_idle, u;
        logic  seen;
        logic [5:0] ext_hold;

        vecs[0] = '{mk_s(F_SYS, 32'hbfc00100, 0, 32'h0, 32'h0, 1),
                    mk_e(1, 5'h08, 0, 32'hbfc00100, 0, 32'h0, 0, VEC)};
        vecs[1] = '{mk_s(F_ADES, 32'h80000010, 1, 32'h80001002, 32'h0, 1),
                    mk_e(1, 5'h05, 0, 32'h8000000c, 1, 32'h80001002, 1, VEC)};
        vecs[2] = '{mk_s(F_ADEL_IF | F_RI, 32'h80000003, 0, 32'h0, 32'h0, 1),
                    mk_e(1, 5'h04, 0, 32'h80000003, 0, 32'h80000003, 1, VEC)};
        vecs[3] = '{mk_s(F_RI | F_OV | F_ADES, 32'h80000020, 0, 32'h7, 32'h0, 1),
                    mk_e(1, 5'h0a, 0, 32'h80000020, 0, 32'h0, 0, VEC)};
        vecs[4] = '{mk_s(F_OV | F_SYS | F_BP, 32'h80000024, 1, 32'h0, 32'h0, 1),
                    mk_e(1, 5'h0c, 0, 32'h80000020, 1, 32'h0, 0, VEC)};
        vecs[5] = '{mk_s(F_SYS | F_BP | F_ERET, 32'h80000030, 0, 32'h0, 32'h80000200, 1),
                    mk_e(1, 5'h08, 0, 32'h80000030, 0, 32'h0, 0, VEC)};
        vecs[6] = '{mk_s(F_BP | F_ERET | F_ADEL_D, 32'h80000034, 0, 32'h3, 32'h80000200, 1),
                    mk_e(1, 5'h09, 0, 32'h80000034, 0, 32'h0, 0, VEC)};
        vecs[7] = '{mk_s(F_ERET | F_ADEL_D, 32'h80000040, 0, 32'h11, 32'h80000200, 1),
                    mk_e(1, 5'h00, 1, 32'h80000040, 0, 32'h0, 0, 32'h80000200)};
        vecs[8] = '{mk_s(F_ADEL_D | F_ADES, 32'h80000050, 0, 32'h80000401, 32'h0, 1),
                    mk_e(1, 5'h04, 0, 32'h80000050, 0, 32'h80000401, 1, VEC)};
        vecs[9] = '{mk_s(F_SYS, 32'h80000060, 0, 32'h0, 32'h0, 0),
                    mk_e(0, 5'h00, 0, 32'h0, 0, 32'h0, 0, 32'h0)};

        // Reset state
        do_reset();
        check("reset flush", flush, 0);
        check("reset stall", stall_req, 0);
        check("reset commit", exc_commit, 0);
        check("reset newpc", newpc, 0);
        check("reset exccode", exccode, 0);
        check("reset hw_ip", hw_ip, 0);

        // Directed single-event vectors, mem idle, spaced two cycles apart
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].s);
            tick();
            drive('0);
            if (vecs[i].e.ev) begin
                check_rec($sformatf("vec%0d", i), vecs[i].e);
            end else begin
                check($sformatf("vec%0d no flush", i), flush, 0);
                check($sformatf("vec%0d no stall", i), stall_req, 0);
            end
            tick();
            check($sformatf("vec%0d one-cycle flush", i), flush, 0);
        end

        // Interrupt through the synchroniser beats a concurrent Ov; EXL masks it
        do_reset();
        s = '0;
        s.ext    = 6'h01;
        s.status = 32'h0000_0401;
        drive(s);
        for (int k = 1; k <= S; k++) begin
            tick();
            check($sformatf("sync latency k=%0d", k), hw_ip[0], (k == S));
        end
        s.valid = 1'b1; s.flags = F_OV; s.pc = 32'h80000100;
        drive(s);
        tick();
        check_rec("int over ov", mk_e(1, 5'h00, 0, 32'h80000100, 0, 0, 0, VEC));
        s.valid = 1'b0;
        drive(s);
        tick();
        s.status = 32'h0000_0403; s.valid = 1'b1;
        drive(s);
        tick();
        check_rec("exl masks int", mk_e(1, 5'h0c, 0, 32'h80000100, 0, 0, 0, VEC));
        s = '0;
        drive(s);
        tick();

        // ERET held off by a 3-cycle data transaction; epc sampled at detection
        s = mk_s(F_ERET, 32'h80000300, 0, 32'h0, 32'h80000200, 1);
        s.busy = 1'b1;
        drive(s);
        tick();
        s = '0; s.epc = 32'h12345678; s.busy = 1'b1;
        drive(s);
        nst = 0; n = 0;
        while (!flush && n < 12) begin
            if (stall_req) nst++;
            mem_busy = (n < 2);
            tick();
            n++;
        end
        check("eret stall cycles", nst, 3);
        check_rec("eret wait", mk_e(1, 5'h00, 1, 32'h80000300, 0, 0, 0, 32'h80000200));
        drive('0);
        tick();

        // Reset while waiting on memory discards the event
        s = mk_s(F_SYS, 32'h80000400, 0, 32'h0, 32'h0, 1);
        s.busy = 1'b1;
        drive(s);
        tick();
        check("wait stall", stall_req, 1);
        rst = 1'b1;
        drive('0);
        tick();
        rst = 1'b0;
        check("rst-in-wait outputs",
              {31'b0, |{flush, stall_req, exc_commit, is_eret, bd_o, bva_we, exccode,
                        newpc, epc_o, badvaddr_o, hw_ip}}, 0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen |= flush;
            tick();
        end
        check("rst-in-wait no flush", seen, 0);
        drive(mk_s(F_BP, 32'h80000500, 0, 32'h0, 32'h0, 1));
        tick();
        drive('0);
        check_rec("idle after rst", mk_e(1, 5'h09, 0, 32'h80000500, 0, 0, 0, VEC));
        tick();

`ifdef TIMER_INT_EN
        // Count/Compare timer raises hw_ip[5]; a Compare write clears it
        do_reset();
        cp0_we = 1'b1; cp0_waddr = CP0_COMPARE; cp0_wdata = 32'd20;
        tick();
        cp0_waddr = CP0_COUNT; cp0_wdata = 32'd0;
        tick();
        cp0_we = 1'b0;
        s = '0; s.status = 32'h0000_8001;
        drive(s);
        n = 0;
        while (!hw_ip[5] && n < 100) begin
            tick();
            n++;
        end
        check("timer rise window", (n >= 36 && n <= 46), 1);
        s.valid = 1'b1; s.pc = 32'h80000600;
        drive(s);
        tick();
        s.valid = 1'b0;
        drive(s);
        check_rec("timer int", mk_e(1, 5'h00, 0, 32'h80000600, 0, 0, 0, VEC));
        tick();
        cp0_we = 1'b1; cp0_waddr = CP0_COMPARE; cp0_wdata = 32'd1000;
        tick();
        cp0_we = 1'b0;
        check("timer cleared", hw_ip[5], 0);
`endif

        // Randomized trace against the trace-level model
        ext_hold = '0;
        for (int c = 0; c < NC; c++) begin
            s = '0;
            if ($urandom_range(0, 7) == 0) ext_hold = 6'($urandom);
            s.ext          = ext_hold;
            s.valid        = ($urandom_range(0, 3) != 0);
            s.pc           = $urandom;
            s.ds           = ($urandom_range(0, 1) == 1);
            s.daddr        = $urandom;
            for (int b = 0; b < 8; b++) s.flags[b] = ($urandom_range(0, 9) == 0);
            s.status[15:8] = 8'($urandom);
            s.status[1]    = ($urandom_range(0, 3) == 0);
            s.status[0]    = ($urandom_range(0, 1) == 1);
            s.csw          = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            s.epc          = $urandom;
            s.busy         = ($urandom_range(0, 9) < 4);
            if (c >= NC - 8) begin
                s.busy = 1'b0; s.valid = 1'b0;
            end
            st[c] = s;
            hw[c] = (c >= S) ? st[c-S].ext : 6'h00;
        end
        for (int c = 0; c < NC + 2; c++) begin
            fl[c] = 1'b0; stl[c] = 1'b0; cm[c] = 1'b0;
        end
        cur = '0;
        next_idle = 0;
        for (int c = 0; c < NC; c++) begin
            vis[c] = cur;
            if (c >= next_idle) begin
                e = model(st[c], hw[c]);
                if (e.ev) begin
                    u = c;
                    while (u < NC - 1 && st[u].busy) u++;
                    for (int k = c + 1; k <= u; k++) stl[k] = 1'b1;
                    fl[u+1] = 1'b1;
                    cm[u+1] = !e.eret;
                    next_idle = u + 2;
                    cur = e;
                end
            end
        end

        do_reset();
`ifdef TIMER_INT_EN
        cp0_we = 1'b1; cp0_waddr = CP0_COMPARE; cp0_wdata = 32'hffff0000;
`endif
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rnd flush c=%0d", c), flush, fl[c]);
            check($sformatf("rnd stall c=%0d", c), stall_req, stl[c]);
            check($sformatf("rnd commit c=%0d", c), exc_commit, cm[c]);
            check($sformatf("rnd hw_ip c=%0d", c), hw_ip, hw[c]);
            if (fl[c]) begin
                check($sformatf("rnd newpc c=%0d", c), newpc, vis[c].newpc);
                check($sformatf("rnd is_eret c=%0d", c), is_eret, vis[c].eret);
                check($sformatf("rnd epc_o c=%0d", c), epc_o, vis[c].epc);
                check($sformatf("rnd bd_o c=%0d", c), bd_o, vis[c].bd);
                check($sformatf("rnd bva_we c=%0d", c), bva_we, vis[c].bva_we);
                if (!vis[c].eret) check($sformatf("rnd exccode c=%0d", c), exccode, vis[c].code);
                if (vis[c].bva_we) check($sformatf("rnd badvaddr c=%0d", c), badvaddr_o, vis[c].bva);
            end
            drive(st[c]);
            tick();
            cp0_we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Parametrised, registered exception controller for the MIPS core's M stage. It replaces the purely combinational M-stage exception resolution. It synchronises external interrupt lines and resolves exception priority. It holds the redirect while a sram-like data transaction is outstanding, then issues a one-cycle flush/commit pulse carrying the CP0 update data (EPC, Cause.BD, ExcCode, BadVAddr) and the new PC.

## Interface
Parameters:
- N_EXT_INT, 6, number of external interrupt lines (1..6); missing lines read as 0 in Cause.IP[7:2]
- SYNC_STAGES, 2, flop stages on each ext_int line (≥1)
- EXC_VECTOR, 32'hbfc00380, redirect target for every exception except ERET

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- ext_int  in  N_EXT_INT  asynchronous level interrupt requests
- valid_m  in  1  M-stage instruction valid (not a bubble)
- pc_m  in  32  M-stage PC
- in_ds_m  in  1  M-stage instruction is in a branch delay slot
- daddr_m  in  32  M-stage data address
- adel_if, ri, ov, sys, bp, eret, adel_d, ades  in  1 each  exception flags from earlier stages
- status  in  32  CP0 Status (uses IM[15:8], EXL[1], IE[0])
- cause_sw  in  2  CP0 Cause.IP[1:0]
- epc  in  32  CP0 EPC
- cp0_we, cp0_waddr[4:0], cp0_wdata[31:0]  in  CP0 write port (used for Count/Compare)
- mem_busy  in  1  data-side sram-like transaction outstanding
- stall_req  out  1  freeze pipeline while exception pending
- flush  out  1  one-cycle pipeline flush / PC redirect strobe
- newpc  out  32  redirect target, valid with flush
- exc_commit  out  1  CP0 update strobe (flush and not ERET)
- is_eret  out  1  committed event is ERET, valid with flush
- exccode  out  5  Cause.ExcCode, valid with exc_commit
- epc_o  out  32  EPC value to write
- bd_o  out  1  Cause.BD
- badvaddr_o  out  32  BadVAddr value to write
- bva_we  out  1  write BadVAddr (AdEL/AdES only)
- hw_ip  out  6  synchronised Cause.IP[7:2] for CP0

## Operation
- Interrupt detection:
  - pending = |({hw_ip, cause_sw} & status[15:8]) && !EXL && IE && valid_m.
- Priority, high to low:
  - INT 0x00
  - AdEL fetch 0x04 (badvaddr = pc_m)
  - RI 0x0a
  - Ov 0x0c
  - Sys 0x08
  - Bp 0x09
  - ERET
  - AdEL data 0x04 (badvaddr = daddr_m)
  - AdES 0x05 (badvaddr = daddr_m)
- Flags are honoured only when valid_m=1.
- Latched record: exccode, is_eret, epc_o = in_ds_m ? pc_m-4 : pc_m, bd_o = in_ds_m, badvaddr_o, bva_we.
- newpc = is_eret ? epc : EXC_VECTOR.
  - epc is sampled at detection, not at flush.
- FSM states IDLE, WAIT_MEM, FLUSH:
  - IDLE: on event with mem_busy=0, latch and go to FLUSH. On event with mem_busy=1, latch and go to WAIT_MEM.
  - WAIT_MEM: stall_req=1; go to FLUSH on the first cycle mem_busy=0.
  - FLUSH: flush=1, exc_commit=!is_eret, stall_req=0; return to IDLE.
- New events are ignored in WAIT_MEM and FLUSH.
  - The pipeline is frozen; the younger instruction is flushed anyway.
- All outputs reset to 0; FSM resets to IDLE; synchroniser flops reset to 0.
- rst in any state returns to IDLE next edge; the latched event is discarded and no flush is issued.

## Timing
- ext_int to hw_ip: SYNC_STAGES cycles.
- Detection at edge T; flush at cycle T+1 when mem_busy=0. Otherwise flush occurs 1 cycle after mem_busy first samples 0.
- stall_req is high in the detection cycle if mem_busy=1, and stays high through WAIT_MEM.
- flush and exc_commit are exactly 1 cycle wide. The record outputs hold until the next latch.
- Back-to-back events: minimum spacing is 2 cycles; the first IDLE cycle after FLUSH may detect again.

## Configuration
- TIMER_INT_EN:
  - Defined: internal Count (reg 9) and Compare (reg 11) shadow registers. Count increments every second cycle and is writable via the CP0 port. When Count==Compare, timer_pending is set. timer_pending is OR'd into hw_ip[5] after synchronisation muxing, and is cleared by a Compare write.
  - Undefined: hw_ip[5] comes only from ext_int[5] (or 0); the Count/Compare logic is absent.

## Structure
- Shared package except_pkg:
  - ExcCode constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - FSM state enum.
  - CP0 register numbers: CP0_COUNT, CP0_COMPARE.
- Sub-module int_sync: per-line SYNC_STAGES flop chain with synchronous reset, instantiated once, N_EXT_INT wide.

## Test plan
- Sys with valid_m=1, pc_m=0xbfc00100, mem_busy=0 -> flush at T+1, exccode=0x08, epc_o=0xbfc00100, newpc=0xbfc00380, bva_we=0.
- AdES in delay slot, pc_m=0x80000010, daddr_m=0x80001002 -> epc_o=0x8000000c, bd_o=1, badvaddr_o=0x80001002, exccode=0x05.
- ext_int[0] high, IM[2]=1, IE=1, EXL=0, concurrent ov -> after SYNC_STAGES, INT wins with exccode=0x00. Repeat with EXL=1 -> Ov taken instead.
- ERET with epc=0x80000200, mem_busy=1 for 3 cycles -> stall_req high 3 cycles, then flush with newpc=0x80000200, is_eret=1, exc_commit=0.
- rst asserted in WAIT_MEM -> next cycle state IDLE, flush never pulses, all outputs 0.
- TIMER_INT_EN: write Compare=20, Count=0, IM[7]=1 -> hw_ip[5] rises near cycle 40, interrupt taken. Writing Compare clears hw_ip[5].
